// File: rtl/m_w_dmem_stage.sv
// ---------------------------------------------------------------------------
// m_w_dmem_stage
//   Memory stage of the 5-stage MIPS pipeline fused with the M/W pipeline
//   register. It takes the E->M register outputs and performs the word-wide
//   data-memory access. It registers everything the write-back stage needs.
//   It also produces the final register-file write value (WD3W) and the
//   decremented Tnew used by the hazard unit.
//
// Parameters
//   AW            word-address width; memory holds 2**AW 32-bit words
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset (clears W regs and memory)
//   RegWriteM     instruction in M writes the register file
//   MemtoRegM     W result select: 00 ALU, 01 mem, 10 PC+8, 11 ext_imm
//   MemWriteM     store word this cycle
//   ALUoutM       byte address / ALU result
//   WriteDataM    store data (already forwarded)
//   WriteRegM     destination register
//   PC_4M         PC+4 of the instruction in M
//   ext_immM      extended immediate
//   TnewM         cycles until the result is ready, as seen in M
//   ReadDataM     combinational read of ALUoutM (M-stage forwarding only)
//   RegWriteW     registered write enable, forced low for register $0
//   WriteRegW     registered destination register
//   MemtoRegW     registered result select
//   ALUoutW       registered ALU result
//   ReadDataW     registered memory read data
//   PC_4W         registered PC+4
//   ext_immW      registered immediate
//   TnewW         registered Tnew, decremented and saturating at 0
//   WD3W          write-back value selected by MemtoRegW
// ---------------------------------------------------------------------------
module m_w_dmem_stage #(
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic [1:0]  MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUoutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  input  logic [31:0] PC_4M,
  input  logic [31:0] ext_immM,
  input  logic [1:0]  TnewM,
  output logic [31:0] ReadDataM,
  output logic        RegWriteW,
  output logic [4:0]  WriteRegW,
  output logic [1:0]  MemtoRegW,
  output logic [31:0] ALUoutW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PC_4W,
  output logic [31:0] ext_immW,
  output logic [1:0]  TnewW,
  output logic [31:0] WD3W
);

  localparam int DEPTH = 1 << AW;

  // Result-select encodings
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC8 = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  // -------------------------------------------------------------------------
  // Data memory
  // -------------------------------------------------------------------------
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] mem_idx;

  // Byte-offset bits and address bits above the array are dropped, so
  // addresses wrap modulo the memory size.
  assign mem_idx   = ALUoutM[AW+1:2];
  assign ReadDataM = mem_q[mem_idx];

  // NOTE: the memory is reset word by word because software relies on a
  // zeroed data memory after reset. That makes it a flop array, not a RAM
  // macro, which is acceptable at this depth for this core.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (MemWriteM) begin
      // NOTE: non-blocking assignment keeps the read above, and the
      // ReadDataW capture below, on the pre-edge word (read-before-write).
      mem_q[mem_idx] <= WriteDataM;
    end
  end

  // -------------------------------------------------------------------------
  // M/W pipeline register
  // -------------------------------------------------------------------------
  logic        reg_write_w_d,  reg_write_w_q;
  logic [4:0]  write_reg_w_d,  write_reg_w_q;
  logic [1:0]  mem_to_reg_w_d, mem_to_reg_w_q;
  logic [31:0] alu_out_w_d,    alu_out_w_q;
  logic [31:0] read_data_w_d,  read_data_w_q;
  logic [31:0] pc_4_w_d,       pc_4_w_q;
  logic [31:0] ext_imm_w_d,    ext_imm_w_q;
  logic [1:0]  tnew_w_d,       tnew_w_q;

  always_comb begin
    // NOTE: every always_comb output is assigned on every path, so no latch
    // can be inferred.
    reg_write_w_d  = RegWriteM && (WriteRegM != 5'd0);  // $0 is never written
    write_reg_w_d  = WriteRegM;
    mem_to_reg_w_d = MemtoRegM;
    alu_out_w_d    = ALUoutM;
    read_data_w_d  = ReadDataM;
    pc_4_w_d       = PC_4M;
    ext_imm_w_d    = ext_immM;
    // Tnew counts down one per stage and saturates at 0.
    tnew_w_d       = (TnewM == 2'd0) ? 2'd0 : TnewM - 2'd1;
  end

  // There is no stall or flush input, so the register loads every cycle.
  // Bubbles arrive as all-zero M inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_w_q  <= 1'b0;
      write_reg_w_q  <= '0;
      mem_to_reg_w_q <= SEL_ALU;
      alu_out_w_q    <= '0;
      read_data_w_q  <= '0;
      pc_4_w_q       <= '0;
      ext_imm_w_q    <= '0;
      tnew_w_q       <= '0;
    end else begin
      reg_write_w_q  <= reg_write_w_d;
      write_reg_w_q  <= write_reg_w_d;
      mem_to_reg_w_q <= mem_to_reg_w_d;
      alu_out_w_q    <= alu_out_w_d;
      read_data_w_q  <= read_data_w_d;
      pc_4_w_q       <= pc_4_w_d;
      ext_imm_w_q    <= ext_imm_w_d;
      tnew_w_q       <= tnew_w_d;
    end
  end

  assign RegWriteW = reg_write_w_q;
  assign WriteRegW = write_reg_w_q;
  assign MemtoRegW = mem_to_reg_w_q;
  assign ALUoutW   = alu_out_w_q;
  assign ReadDataW = read_data_w_q;
  assign PC_4W     = pc_4_w_q;
  assign ext_immW  = ext_imm_w_q;
  assign TnewW     = tnew_w_q;

  // -------------------------------------------------------------------------
  // Write-back value
  // -------------------------------------------------------------------------
  always_comb begin
    WD3W = alu_out_w_q;
    case (mem_to_reg_w_q)
      SEL_ALU: WD3W = alu_out_w_q;
      SEL_MEM: WD3W = read_data_w_q;
      SEL_PC8: WD3W = pc_4_w_q + 32'd4;   // link address PC+8, wraps at 2**32
      SEL_IMM: WD3W = ext_imm_w_q;
      default: WD3W = alu_out_w_q;
    endcase
  end

endmodule

// File: tb/tb_m_w_dmem_stage.sv
// ---------------------------------------------------------------------------
// tb_m_w_dmem_stage
//   Directed bench for m_w_dmem_stage (AW = 10). Inputs change 1 time unit
//   after each rising edge. Outputs are checked after that edge, once the new
//   register contents have settled.
// ---------------------------------------------------------------------------
module tb_m_w_dmem_stage;

  logic        clk;
  logic        reset;
  logic        RegWriteM;
  logic [1:0]  MemtoRegM;
  logic        MemWriteM;
  logic [31:0] ALUoutM;
  logic [31:0] WriteDataM;
  logic [4:0]  WriteRegM;
  logic [31:0] PC_4M;
  logic [31:0] ext_immM;
  logic [1:0]  TnewM;
  logic [31:0] ReadDataM;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [1:0]  MemtoRegW;
  logic [31:0] ALUoutW;
  logic [31:0] ReadDataW;
  logic [31:0] PC_4W;
  logic [31:0] ext_immW;
  logic [1:0]  TnewW;
  logic [31:0] WD3W;

  int checks = 0;
  int errors = 0;

  m_w_dmem_stage #(.AW(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .ALUoutM    (ALUoutM),
    .WriteDataM (WriteDataM),
    .WriteRegM  (WriteRegM),
    .PC_4M      (PC_4M),
    .ext_immM   (ext_immM),
    .TnewM      (TnewM),
    .ReadDataM  (ReadDataM),
    .RegWriteW  (RegWriteW),
    .WriteRegW  (WriteRegW),
    .MemtoRegW  (MemtoRegW),
    .ALUoutW    (ALUoutW),
    .ReadDataW  (ReadDataW),
    .PC_4W      (PC_4W),
    .ext_immW   (ext_immW),
    .TnewW      (TnewW),
    .WD3W       (WD3W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and leave time for outputs to settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a bubble: all M inputs zero.
  task automatic bubble();
    RegWriteM  = 1'b0;
    MemtoRegM  = 2'b00;
    MemWriteM  = 1'b0;
    ALUoutM    = '0;
    WriteDataM = '0;
    WriteRegM  = '0;
    PC_4M      = '0;
    ext_immM   = '0;
    TnewM      = '0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bubble();
    MemWriteM  = 1'b1;
    ALUoutM    = addr;
    WriteDataM = data;
    step();
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] rd);
    bubble();
    RegWriteM = 1'b1;
    MemtoRegM = 2'b01;
    ALUoutM   = addr;
    WriteRegM = rd;
    step();
  endtask

  task automatic test_reset();
    bubble();
    reset      = 1'b1;
    MemWriteM  = 1'b1;
    WriteDataM = 32'hDEAD_BEEF;
    ALUoutM    = 32'h0;
    RegWriteM  = 1'b1;
    WriteRegM  = 5'd7;
    MemtoRegM  = 2'b10;
    PC_4M      = 32'h1000;
    ext_immM   = 32'h55;
    TnewM      = 2'd3;
    step();
    step();
    checks++;
    if ({RegWriteW, WriteRegW, MemtoRegW, TnewW} !== 10'd0) begin
      errors++;
      $display("FAIL reset_ctrl got RegWriteW=%0b WriteRegW=%0d MemtoRegW=%0d TnewW=%0d want all 0",
               RegWriteW, WriteRegW, MemtoRegW, TnewW);
    end
    checks++;
    if ({ALUoutW, ReadDataW, PC_4W, ext_immW, WD3W} !== 160'd0) begin
      errors++;
      $display("FAIL reset_data got ALUoutW=%h ReadDataW=%h PC_4W=%h ext_immW=%h WD3W=%h want 0",
               ALUoutW, ReadDataW, PC_4W, ext_immW, WD3W);
    end
    reset = 1'b0;
    load(32'h0, 5'd1);
    checks++;
    if (ReadDataW !== 32'h0 || WD3W !== 32'h0) begin
      errors++;
      $display("FAIL reset_store_discard got ReadDataW=%h WD3W=%h want 0", ReadDataW, WD3W);
    end
  endtask

  task automatic test_sw_lw();
    store(32'h0000_0010, 32'h1234_5678);
    bubble();
    RegWriteM = 1'b1;
    MemtoRegM = 2'b01;
    ALUoutM   = 32'h10;
    WriteRegM = 5'd8;
    #1;
    checks++;
    if (ReadDataM !== 32'h1234_5678) begin
      errors++;
      $display("FAIL sw_lw_readdatam got %h want 12345678", ReadDataM);
    end
    step();
    checks++;
    if (ReadDataW !== 32'h1234_5678 || WD3W !== 32'h1234_5678) begin
      errors++;
      $display("FAIL sw_lw_data got ReadDataW=%h WD3W=%h want 12345678", ReadDataW, WD3W);
    end
    checks++;
    if (WriteRegW !== 5'd8 || RegWriteW !== 1'b1 || MemtoRegW !== 2'b01 || ALUoutW !== 32'h10) begin
      errors++;
      $display("FAIL sw_lw_ctrl got WriteRegW=%0d RegWriteW=%0b MemtoRegW=%0d ALUoutW=%h want 8 1 1 10",
               WriteRegW, RegWriteW, MemtoRegW, ALUoutW);
    end
  endtask

  task automatic test_wrap();
    // 0x1004 -> word 0x401 -> index 1; 0x7 -> index 1
    store(32'h0000_1004, 32'hA5A5_A5A5);
    load(32'h0000_0007, 5'd9);
    checks++;
    if (ReadDataW !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL wrap_align got %h want a5a5a5a5", ReadDataW);
    end
    // Neighbouring word must be untouched.
    load(32'h0000_0008, 5'd9);
    checks++;
    if (ReadDataW !== 32'h0) begin
      errors++;
      $display("FAIL wrap_neighbour got %h want 0", ReadDataW);
    end
  endtask

  task automatic test_read_before_write();
    store(32'hC, 32'h1);
    bubble();
    MemWriteM  = 1'b1;
    MemtoRegM  = 2'b01;
    ALUoutM    = 32'hC;
    WriteDataM = 32'h2;
    step();
    checks++;
    if (ReadDataW !== 32'h1 || WD3W !== 32'h1) begin
      errors++;
      $display("FAIL rbw_old got ReadDataW=%h WD3W=%h want 1", ReadDataW, WD3W);
    end
    load(32'hC, 5'd3);
    checks++;
    if (ReadDataW !== 32'h2) begin
      errors++;
      $display("FAIL rbw_new got %h want 2", ReadDataW);
    end
  endtask

  task automatic test_wd3_select();
    bubble();
    RegWriteM = 1'b1;
    WriteRegM = 5'd31;
    MemtoRegM = 2'b10;
    PC_4M     = 32'h3004;
    step();
    checks++;
    if (WD3W !== 32'h3008 || PC_4W !== 32'h3004) begin
      errors++;
      $display("FAIL wd3_pc8 got WD3W=%h PC_4W=%h want 3008 3004", WD3W, PC_4W);
    end
    PC_4M = 32'hFFFF_FFFC;
    step();
    checks++;
    if (WD3W !== 32'h0) begin
      errors++;
      $display("FAIL wd3_pc8_wrap got %h want 0", WD3W);
    end
    bubble();
    RegWriteM = 1'b1;
    WriteRegM = 5'd4;
    MemtoRegM = 2'b11;
    ext_immM  = 32'hFFFF_0000;
    ALUoutM   = 32'h1111_1111;
    step();
    checks++;
    if (WD3W !== 32'hFFFF_0000 || ext_immW !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL wd3_imm got WD3W=%h ext_immW=%h want ffff0000", WD3W, ext_immW);
    end
    MemtoRegM = 2'b00;
    ALUoutM   = 32'h0000_CAFE;
    step();
    checks++;
    if (WD3W !== 32'h0000_CAFE) begin
      errors++;
      $display("FAIL wd3_alu got %h want 0000cafe", WD3W);
    end
    WriteRegM = 5'd0;
    step();
    checks++;
    if (RegWriteW !== 1'b0) begin
      errors++;
      $display("FAIL reg0_write got RegWriteW=%0b want 0", RegWriteW);
    end
  endtask

  task automatic test_tnew();
    logic [1:0] tin  [4];
    logic [1:0] tout [4];
    tin  = '{2'd2, 2'd1, 2'd0, 2'd3};
    tout = '{2'd1, 2'd0, 2'd0, 2'd2};
    for (int i = 0; i < 4; i++) begin
      bubble();
      TnewM = tin[i];
      step();
      checks++;
      if (TnewW !== tout[i]) begin
        errors++;
        $display("FAIL tnew_%0d got %0d want %0d", tin[i], TnewW, tout[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    store(32'h20, 32'h55);
    bubble();
    reset     = 1'b1;
    RegWriteM = 1'b1;
    WriteRegM = 5'd9;
    ALUoutM   = 32'h77;
    step();
    checks++;
    if (RegWriteW !== 1'b0 || WriteRegW !== 5'd0 || ALUoutW !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_w got RegWriteW=%0b WriteRegW=%0d ALUoutW=%h want 0",
               RegWriteW, WriteRegW, ALUoutW);
    end
    reset = 1'b0;
    load(32'h20, 5'd9);
    checks++;
    if (ReadDataW !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_mem got %h want 0", ReadDataW);
    end
  endtask

  initial begin
    reset = 1'b1;
    bubble();
    test_reset();
    test_sw_lw();
    test_wrap();
    test_read_before_write();
    test_wd3_select();
    test_tnew();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
